// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz raster timing shared by the sync generator and the pixel stage.
package vga_timing_pkg;

  localparam int COORD_W  = 10;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

endpackage

// File: rtl/pixel_tick_gen.sv
// One-clock strobe every CLK_DIV clocks; phase restarts at reset so the strobe
// lands in cycle CLK_DIV-1 after release.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int                CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Gating with reset keeps the strobe quiet while reset is held, even at CLK_DIV=1.
  assign o_tick = w_last & ~i_reset;

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("pixel_tick_gen: CLK_DIV must be in 1..16");
  end

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing: pixel strobe, x/y counters, registered sync and active-video flags.
module vga_sync #(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_timing_pkg::H_FP,
  parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int   H_BP     = vga_timing_pkg::H_BP,
  parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_timing_pkg::V_FP,
  parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int   V_BP     = vga_timing_pkg::V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic                               clk,
  input  logic                               reset,
  output logic                               p_tick,
  output logic [vga_timing_pkg::COORD_W-1:0] x,
  output logic [vga_timing_pkg::COORD_W-1:0] y,
  output logic                               hsync,
  output logic                               vsync,
  output logic                               video_on,
  output logic                               frame_start
);

  import vga_timing_pkg::*;

  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_TOT - 1);

  if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
    $error("vga_sync: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic               w_tick;
  logic [COORD_W-1:0] w_next_x;
  logic [COORD_W-1:0] w_next_y;
  logic               w_hs_act;
  logic               w_vs_act;
  logic               w_von;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_video_on;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .i_clk   (clk),
    .i_reset (reset),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_next_x = r_x + COORD_W'(1);
    w_next_y = r_y;
    if (r_x == X_LAST) begin
      w_next_x = '0;
      w_next_y = (r_y == Y_LAST) ? '0 : r_y + COORD_W'(1);
    end
  end

  // Decode from the next position so the flags stay aligned with x/y without output logic.
  assign w_hs_act = (int'(w_next_x) >= HS_START) && (int'(w_next_x) < HS_END);
  assign w_vs_act = (int'(w_next_y) >= VS_START) && (int'(w_next_y) < VS_END);
  assign w_von    = (int'(w_next_x) < H_ACTIVE) && (int'(w_next_y) < V_ACTIVE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x        <= '0;
      r_y        <= '0;
      r_hsync    <= ~SYNC_POL;
      r_vsync    <= ~SYNC_POL;
      r_video_on <= 1'b1;
    end else if (w_tick) begin
      r_x        <= w_next_x;
      r_y        <= w_next_y;
      r_hsync    <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync    <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_video_on <= w_von;
    end
  end

  assign p_tick      = w_tick;
  assign x           = r_x;
  assign y           = r_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign frame_start = w_tick && (r_x == '0) && (r_y == '0);

endmodule
